// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver for the stopwatch display.
// Snapshots the BCD count once per frame; guard-blanks each slot; blinks the colon while running.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD        = 4,
    parameter int BLINK_FRAMES = 50
) (
    input  logic        clk_in,
    input  logic        RESET_N,
    input  logic [15:0] Q,
    input  logic        ON_OFF,
    input  logic        LZB,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [3:0]  AN
);
    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] GUARD_END  = TW'(GUARD);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          dp_phase_q, dp_phase_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;

    logic          frame_start;
    logic [3:0]    nib;
    logic [6:0]    seg_dec;

    always_comb begin
        tick_d      = tick_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        blink_cnt_d = blink_cnt_q;
        dp_phase_d  = dp_phase_q;
        an_d        = 4'hF;
        seg_d       = 7'h7F;
        dp_d        = 1'b1;
        nib         = 4'h0;
        seg_dec     = 7'b0111111;

        frame_start = (tick_q == '0) && (idx_q == 2'd0);

        if (tick_q == TICK_LAST) begin
            tick_d = '0;
            idx_d  = idx_q + 2'd1;
        end else begin
            tick_d = tick_q + TW'(1);
        end

        if (frame_start) begin
            snap_d = Q;
        end

        // Stopped: hold the colon steady so a restart begins a full lit half-period.
        if (!ON_OFF) begin
            blink_cnt_d = '0;
            dp_phase_d  = 1'b1;
        end else if (frame_start) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                dp_phase_d  = ~dp_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end

        case (idx_q)
            2'd0:    nib = snap_q[3:0];
            2'd1:    nib = snap_q[7:4];
            2'd2:    nib = snap_q[11:8];
            default: nib = snap_q[15:12];
        endcase

        case (nib)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'b0111111;
        endcase

        // Blanked d3 still drives its anode so every slot has the same timing.
        if (tick_q >= GUARD_END) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = (idx_q == 2'd3 && LZB && nib == 4'h0) ? 7'h7F : seg_dec;
            dp_d  = ~((idx_q == 2'd2) && dp_phase_q);
        end
    end

    always_ff @(posedge clk_in or negedge RESET_N) begin
        if (!RESET_N) begin
            tick_q      <= '0;
            idx_q       <= 2'd0;
            snap_q      <= 16'h0000;
            blink_cnt_q <= '0;
            dp_phase_q  <= 1'b1;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            an_q        <= 4'hF;
        end else begin
            tick_q      <= tick_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            blink_cnt_q <= blink_cnt_d;
            dp_phase_q  <= dp_phase_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign SEG = seg_q;
    assign DP  = dp_q;
    assign AN  = an_q;
endmodule
